fir_mac_fold: RTL
=================

FIR_MAC_FOLD -- requirements
Module: fir_mac_fold

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 13: signed tap and output sample width.
REQ-002 SHALL have parameter COEF_WIDTH, default 13: signed coefficient width, format Q1.(COEF_WIDTH-1).
REQ-003 SHALL have parameter TAPS, default 8: number of taps, at least 2.
REQ-004 SHALL have port CLK, input, 1: clock, all state updates on rising edge.
REQ-005 SHALL have port RST_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port VIN, input, 1: tap vector valid strobe from the delay line.
REQ-007 SHALL have port TP, input, TAPS x DATA_WIDTH signed unpacked array [0:TAPS-1]: tap vector.
REQ-008 SHALL have port COEF_WE, input, 1: coefficient write enable.
REQ-009 SHALL have port COEF_ADDR, input, clog2(TAPS): coefficient index.
REQ-010 SHALL have port COEF_DIN, input, COEF_WIDTH signed: coefficient write data.
REQ-011 SHALL have port DOUT, output, DATA_WIDTH signed: filtered sample.
REQ-012 SHALL have port VOUT, output, 1: DOUT valid, one-cycle pulse.
REQ-013 SHALL have port BUSY, output, 1: high whenever state is not IDLE.
REQ-014 SHALL have port OVR, output, 1: sticky overrun flag.

Function
REQ-015 SHALL implement FSM IDLE -> MAC -> OUT -> IDLE.
REQ-016 SHALL, in IDLE with VIN=1, snapshot TP into an internal register bank, clear the accumulator and tap counter, and enter MAC.
REQ-017 SHALL, in MAC, add snap[cnt]*coef[cnt] to the accumulator once per cycle, increment cnt, and enter OUT after the step with cnt=TAPS-1.
REQ-018 SHALL size the accumulator ACC_W = DATA_WIDTH+COEF_WIDTH+clog2(TAPS) bits signed, so no internal overflow occurs.
REQ-019 SHALL, in OUT, register DOUT = accumulator arithmetic-shifted right by COEF_WIDTH-1 (floor), reduced per REQ-029/030, set VOUT=1, and enter IDLE.
REQ-020 SHALL hold VOUT high for exactly the one cycle after OUT, and hold DOUT until the next result.
REQ-021 SHALL make VOUT go high for the cycle that follows the rising edge TAPS+1 edges after the edge sampling VIN.
REQ-022 SHALL accept a new VIN during the VOUT cycle, giving a throughput of one sample per TAPS+2 cycles.
REQ-023 SHALL ignore VIN while BUSY=1, set OVR=1, and leave the running computation unaffected.
REQ-024 SHALL write COEF_DIN to coef[COEF_ADDR] on COEF_WE=1 only in IDLE, and ignore writes while BUSY=1.
REQ-025 SHALL, when VIN and COEF_WE occur in the same IDLE cycle, perform the write and use the new coefficient in the computation.

Reset
REQ-026 SHALL, on RST_n=0 at any time including mid-computation, force state IDLE, cnt 0, accumulator 0, snapshot 0, all coefficients 0, DOUT 0, VOUT 0, BUSY 0 and OVR 0.
REQ-027 SHALL clear OVR only by reset.
REQ-028 SHALL, after reset release, accept VIN from the first rising edge.

Configuration
REQ-029 SHALL, with FIR_MAC_SAT_EN defined, saturate the shifted result to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-030 SHALL, without FIR_MAC_SAT_EN, truncate the shifted result to its low DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-031 SHALL place the FSM state enum, the ACC_W width function and the default width constants in shared package fir_pkg.
REQ-032 SHALL implement the shift-and-reduce step as sub-module fir_sat, parameterized by input and output widths and honouring FIR_MAC_SAT_EN.

Verification
REQ-033 SHALL cover the impulse case: coef[0]=2048, other coefficients 0, TP={100,0,...}, VIN pulse -> DOUT=50, VOUT one cycle, 9 cycles after the VIN edge.
REQ-034 SHALL cover positive overflow: all coefficients 4095, all taps 4095 -> with macro DOUT=4095, without macro DOUT=-16.
REQ-035 SHALL cover negative overflow: all coefficients 4095, all taps -4096 -> with macro DOUT=-4096, without macro DOUT=8.
REQ-036 SHALL cover overrun: VIN while BUSY -> OVR=1, the first result is unchanged, no second VOUT, and OVR stays 1 until reset.
REQ-037 SHALL cover a coefficient write while BUSY -> the write is ignored and the read-back result uses the old coefficient.
REQ-038 SHALL cover reset asserted during MAC -> all outputs are 0 immediately, no VOUT afterwards, and the next VIN computes correctly.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type, accumulator width helper and default widths for the folded FIR MAC
package fir_pkg;

    localparam int DATA_W_DEF = 13;
    localparam int COEF_W_DEF = 13;
    localparam int TAPS_DEF   = 8;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_sat.sv
// fir_sat: floor-shift the accumulator and reduce to output width; saturates with FIR_MAC_SAT_EN, wraps otherwise
module fir_sat #(
    parameter int IN_W  = 29,
    parameter int OUT_W = 13,
    parameter int SHIFT = 12
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    logic signed [IN_W-1:0] w_sh;

    assign w_sh = i_din >>> SHIFT;

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    assign o_dout = w_sh > MAXV ? OUT_W'(MAXV) : w_sh < MINV ? OUT_W'(MINV) : OUT_W'(w_sh);
`else
    assign o_dout = OUT_W'(w_sh);
`endif

endmodule

// File: rtl/fir_mac_fold.sv
// fir_mac_fold: single-multiplier folded FIR, one tap per cycle; optional output saturation via FIR_MAC_SAT_EN
module fir_mac_fold
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int COEF_WIDTH = COEF_W_DEF,
    parameter int TAPS       = TAPS_DEF
) (
    input  logic                         CLK,
    input  logic                         RST_n,
    input  logic                         VIN,
    input  logic signed [DATA_WIDTH-1:0] TP [0:TAPS-1],
    input  logic                         COEF_WE,
    input  logic [$clog2(TAPS)-1:0]      COEF_ADDR,
    input  logic signed [COEF_WIDTH-1:0] COEF_DIN,
    output logic signed [DATA_WIDTH-1:0] DOUT,
    output logic                         VOUT,
    output logic                         BUSY,
    output logic                         OVR
);

    localparam int AW   = acc_w(DATA_WIDTH, COEF_WIDTH, TAPS);
    localparam int CNTW = $clog2(TAPS);
    localparam int PW   = DATA_WIDTH + COEF_WIDTH;

    state_t                       r_state, w_next;
    logic [CNTW-1:0]              r_cnt;
    logic signed [AW-1:0]         r_acc;
    logic signed [DATA_WIDTH-1:0] r_snap [0:TAPS-1];
    logic signed [COEF_WIDTH-1:0] r_coef [0:TAPS-1];
    logic signed [PW-1:0]         w_prod;
    logic signed [DATA_WIDTH-1:0] w_res, r_dout;
    logic                         r_vout, r_ovr, w_busy, w_last;

    assign w_busy = r_state != IDLE;
    assign w_last = r_cnt == CNTW'(TAPS - 1);
    assign w_prod = PW'(r_snap[r_cnt]) * PW'(r_coef[r_cnt]);

    // state register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: accept a sample in IDLE, walk all taps, then one output cycle
    always_comb begin
        w_next = r_state == IDLE ? (VIN ? MAC : IDLE)
               : r_state == MAC  ? (w_last ? OUT : MAC)
               : IDLE;
    end

    // datapath: coefficient bank, snapshot, accumulate, output register and sticky overrun
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_snap[i] <= '0;
                r_coef[i] <= '0;
            end
            r_acc  <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_vout <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (!w_busy && COEF_WE) r_coef[COEF_ADDR] <= COEF_DIN;
            if (!w_busy && VIN) begin
                r_snap <= TP;
                r_acc  <= '0;
                r_cnt  <= '0;
            end
            if (r_state == MAC) begin
                r_acc <= r_acc + AW'(w_prod);
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == OUT) r_dout <= w_res;
            r_vout <= r_state == OUT;
            if (w_busy && VIN) r_ovr <= 1'b1;
        end
    end

    fir_sat #(
        .IN_W (AW),
        .OUT_W(DATA_WIDTH),
        .SHIFT(COEF_WIDTH - 1)
    ) u_sat (
        .i_din (r_acc),
        .o_dout(w_res)
    );

    assign DOUT = r_dout;
    assign VOUT = r_vout;
    assign BUSY = w_busy;
    assign OVR  = r_ovr;

endmodule
